// File: rtl/kb_rx_redundancy_mgr.sv
// Redundant KB receive manager: tracks per-channel health, selects one active channel with
// hysteretic revert to ch0 and manual force, and forwards the active channel's frames.
module kb_rx_redundancy_mgr #(
  parameter int NCH         = 2,
  parameter int NWORDS      = 8,
  parameter int W           = 16,
  parameter int TIMEOUT_CYC = 100000,
  parameter int ERR_LIMIT   = 3,
  parameter int STALE_LIMIT = 4,
  parameter int REVERT_GOOD = 16
) (
  input  logic                    clk_100M,
  input  logic                    reset_n,
  input  logic [NCH-1:0]          rx_valid,
  input  logic [NCH-1:0]          rx_err,
  input  logic [NCH*NWORDS*W-1:0] rx_data,
  input  logic [NCH*W-1:0]        rx_renew,
  input  logic                    force_en,
  input  logic [1:0]              force_ch,
  output logic [NWORDS*W-1:0]     out_data,
  output logic [W-1:0]            out_renew,
  output logic                    out_valid,
  output logic [1:0]              active_ch,
  output logic                    link_ok,
  output logic [15:0]             comm_state
);
  localparam int FW   = NWORDS * W;
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam int ER_W = $clog2(ERR_LIMIT + 1);
  localparam int ST_W = $clog2(STALE_LIMIT + 1);
  localparam int GR_W = $clog2(REVERT_GOOD + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);
  localparam logic [ER_W-1:0] ER_MAX = ER_W'(ERR_LIMIT);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(STALE_LIMIT);
  localparam logic [GR_W-1:0] GR_MAX = GR_W'(REVERT_GOOD);

  typedef enum logic [1:0] {NO_LINK = 2'd0, LOCKED = 2'd1, FORCED = 2'd2} state_t;

  logic [NCH-1:0]  good;
  logic [WD_W-1:0] wd_q    [NCH];
  logic [WD_W-1:0] wd_d    [NCH];
  logic [ER_W-1:0] err_q   [NCH];
  logic [ER_W-1:0] err_d   [NCH];
  logic [ST_W-1:0] stale_q [NCH];
  logic [ST_W-1:0] stale_d [NCH];
  logic [W-1:0]    last_q  [NCH];
  logic [W-1:0]    last_d  [NCH];
  logic [NCH-1:0]  healthy_q, healthy_d;
  logic [GR_W-1:0] good0_q, good0_d;
  state_t          state_q, state_d;
  logic [1:0]      act_q, act_d;
  logic [7:0]      sw_q, sw_d;
  logic [FW-1:0]   out_data_q, out_data_d;
  logic [W-1:0]    out_renew_q, out_renew_d;
  logic            out_valid_q, out_valid_d;
  logic [3:0]      health4;
  logic            force_ok, low_any_vld, low_oth_vld;
  logic [1:0]      low_any, low_oth;

  always_comb begin
    good = rx_valid & ~rx_err;
    for (int k = 0; k < NCH; k++) begin
      wd_d[k]    = good[k] ? '0 : ((wd_q[k] == WD_MAX) ? WD_MAX : wd_q[k] + WD_W'(1));
      err_d[k]   = err_q[k];
      stale_d[k] = stale_q[k];
      last_d[k]  = last_q[k];
      if (rx_err[k]) begin
        if (err_q[k] != ER_MAX) err_d[k] = err_q[k] + ER_W'(1);
      end else if (good[k]) begin
        err_d[k] = '0;
      end
      if (good[k]) begin
        last_d[k] = rx_renew[k*W +: W];
        if (rx_renew[k*W +: W] == last_q[k]) begin
          if (stale_q[k] != ST_MAX) stale_d[k] = stale_q[k] + ST_W'(1);
        end else begin
          stale_d[k] = '0;
        end
      end
      healthy_d[k] = (wd_d[k] != WD_MAX) && (err_d[k] != ER_MAX) && (stale_d[k] != ST_MAX);
    end
    good0_d = good0_q;
    if (good[0]) begin
      if (good0_q != GR_MAX) good0_d = good0_q + GR_W'(1);
    end else if (rx_err[0] || (wd_d[0] == WD_MAX)) begin
      good0_d = '0;
    end
  end

  always_comb begin
    health4            = '0;
    health4[NCH-1:0]   = healthy_q;
    force_ok           = force_en && ({1'b0, force_ch} < 3'(NCH));
    low_any_vld        = 1'b0;
    low_any            = '0;
    low_oth_vld        = 1'b0;
    low_oth            = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (healthy_q[k]) begin
        low_any_vld = 1'b1;
        low_any     = 2'(k);
        if (2'(k) != act_q) begin
          low_oth_vld = 1'b1;
          low_oth     = 2'(k);
        end
      end
    end
    state_d = state_q;
    act_d   = act_q;
    if (force_ok) begin
      state_d = FORCED;
      act_d   = force_ch;
    end else begin
      case (state_q)
        NO_LINK: if (low_any_vld) begin
          state_d = LOCKED;
          act_d   = low_any;
        end
        LOCKED: begin
          if (!health4[act_q]) begin
            if (low_oth_vld) act_d = low_oth;
            else state_d = NO_LINK;
          // Revert only onto a healthy ch0, otherwise a stale ch0 would ping-pong the selection.
          end else if ((act_q != 2'd0) && healthy_q[0] && (good0_q == GR_MAX)) begin
            act_d = 2'd0;
          end
        end
        FORCED:  state_d = health4[act_q] ? LOCKED : NO_LINK;
        default: state_d = NO_LINK;
      endcase
    end
    sw_d = sw_q;
    if ((act_d != act_q) && (sw_q != 8'hFF)) sw_d = sw_q + 8'd1;
  end

  // Selection uses the registered active_ch, so a frame coincident with a switch comes from the old channel.
  always_comb begin
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_renew_d = out_renew_q;
    if (state_q != NO_LINK) begin
      for (int k = 0; k < NCH; k++) begin
        if (good[k] && (2'(k) == act_q)) begin
          out_valid_d = 1'b1;
          out_data_d  = rx_data[k*FW +: FW];
          out_renew_d = rx_renew[k*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        wd_q[k]    <= WD_MAX;
        err_q[k]   <= '0;
        stale_q[k] <= '0;
        last_q[k]  <= '0;
      end
      healthy_q   <= '0;
      good0_q     <= '0;
      state_q     <= NO_LINK;
      act_q       <= '0;
      sw_q        <= '0;
      out_data_q  <= '0;
      out_renew_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        wd_q[k]    <= wd_d[k];
        err_q[k]   <= err_d[k];
        stale_q[k] <= stale_d[k];
        last_q[k]  <= last_d[k];
      end
      healthy_q   <= healthy_d;
      good0_q     <= good0_d;
      state_q     <= state_d;
      act_q       <= act_d;
      sw_q        <= sw_d;
      out_data_q  <= out_data_d;
      out_renew_q <= out_renew_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_renew  = out_renew_q;
  assign out_valid  = out_valid_q;
  assign active_ch  = act_q;
  assign link_ok    = (state_q == LOCKED) || ((state_q == FORCED) && health4[act_q]);
  assign comm_state = {sw_q, (state_q == FORCED), link_ok, act_q, health4};

endmodule

// File: tb/tb_kb_rx_redundancy_mgr.sv
// Directed bench for kb_rx_redundancy_mgr with a shortened watchdog (TIMEOUT_CYC=40).
module tb_kb_rx_redundancy_mgr;
  localparam int NCH = 2;
  localparam int NWORDS = 2;
  localparam int W = 16;
  localparam int TO = 40;

  logic        clk_100M = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  rx_valid, rx_err;
  logic [63:0] rx_data;
  logic [31:0] rx_renew;
  logic        force_en;
  logic [1:0]  force_ch;
  logic [31:0] out_data;
  logic [15:0] out_renew;
  logic        out_valid;
  logic [1:0]  active_ch;
  logic        link_ok;
  logic [15:0] comm_state;

  int errors = 0;
  int checks = 0;
  logic [15:0] r0, r1, last;
  int t_unh, t_sw;

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  e;
    logic [15:0] n0;
    logic [15:0] n1;
    logic [15:0] comm;
    logic        ov;
    logic [15:0] orn;
  } vec_t;
  vec_t tbl [10];

  kb_rx_redundancy_mgr #(
    .NCH(NCH), .NWORDS(NWORDS), .W(W), .TIMEOUT_CYC(TO),
    .ERR_LIMIT(3), .STALE_LIMIT(4), .REVERT_GOOD(16)
  ) dut (
    .clk_100M(clk_100M), .reset_n(reset_n), .rx_valid(rx_valid), .rx_err(rx_err),
    .rx_data(rx_data), .rx_renew(rx_renew), .force_en(force_en), .force_ch(force_ch),
    .out_data(out_data), .out_renew(out_renew), .out_valid(out_valid),
    .active_ch(active_ch), .link_ok(link_ok), .comm_state(comm_state)
  );

  always #5 clk_100M = ~clk_100M;

  function automatic logic [31:0] mkframe(input int ch, input logic [15:0] rn);
    logic [31:0] f;
    for (int j = 0; j < NWORDS; j++) f[j*16 +: 16] = {rn[7:0], 4'(ch), 4'(j)};
    return f;
  endfunction

  assign rx_data = {mkframe(1, rx_renew[31:16]), mkframe(0, rx_renew[15:0])};

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic frame(input logic [1:0] v, input logic [1:0] e,
                       input logic [15:0] n0, input logic [15:0] n1);
    rx_valid = v;
    rx_err   = e;
    rx_renew = {n1, n0};
    tick();
    rx_valid = '0;
    rx_err   = '0;
  endtask

  initial begin
    rx_valid = '0; rx_err = '0; rx_renew = '0; force_en = 1'b0; force_ch = '0;
    //                v      e      n0     n1     comm      ov    orn
    tbl[0] = '{2'b00, 2'b00, 16'd0, 16'd0, 16'h0000, 1'b0, 16'd0};
    tbl[1] = '{2'b11, 2'b00, 16'd1, 16'd1, 16'h0003, 1'b0, 16'd0};
    tbl[2] = '{2'b00, 2'b00, 16'd1, 16'd1, 16'h0043, 1'b0, 16'd0};
    tbl[3] = '{2'b11, 2'b00, 16'd2, 16'd2, 16'h0043, 1'b1, 16'd2};
    tbl[4] = '{2'b00, 2'b00, 16'd2, 16'd2, 16'h0043, 1'b0, 16'd2};
    tbl[5] = '{2'b10, 2'b00, 16'd2, 16'd3, 16'h0043, 1'b0, 16'd2};
    tbl[6] = '{2'b01, 2'b01, 16'd3, 16'd3, 16'h0043, 1'b0, 16'd2};
    tbl[7] = '{2'b01, 2'b00, 16'd3, 16'd3, 16'h0043, 1'b1, 16'd3};
    tbl[8] = '{2'b10, 2'b10, 16'd3, 16'd3, 16'h0043, 1'b0, 16'd3};
    tbl[9] = '{2'b01, 2'b00, 16'd3, 16'd3, 16'h0043, 1'b1, 16'd3};

    repeat (3) @(posedge clk_100M);
    @(negedge clk_100M);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      frame(tbl[i].v, tbl[i].e, tbl[i].n0, tbl[i].n1);
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("vec%0d out_renew", i), 64'(out_renew), 64'(tbl[i].orn));
      chk($sformatf("vec%0d comm_state", i), 64'(comm_state), 64'(tbl[i].comm));
      chk($sformatf("vec%0d active_ch", i), 64'(active_ch), 64'(tbl[i].comm[5:4]));
      chk($sformatf("vec%0d link_ok", i), 64'(link_ok), 64'(tbl[i].comm[6]));
      if (tbl[i].ov) chk($sformatf("vec%0d out_data", i), 64'(out_data), 64'(mkframe(0, tbl[i].orn)));
    end

    // ch0 goes silent, ch1 keeps sending every 8 cycles
    r0 = 16'd10; r1 = 16'd10;
    frame(2'b11, 2'b00, r0, r1);
    chk("timeout last ch0 fwd", 64'(out_renew), 64'(r0));
    t_unh = 0; t_sw = 0;
    for (int m = 1; m <= 60; m++) begin
      if (m % 8 == 0) begin
        r1++;
        rx_valid = 2'b10;
        rx_renew[31:16] = r1;
      end
      tick();
      rx_valid = '0;
      if (t_unh == 0 && !comm_state[0]) t_unh = m;
      if (t_sw == 0 && active_ch == 2'd1) t_sw = m;
      if (m == 48) begin
        chk("timeout ch1 out_valid", 64'(out_valid), 64'd1);
        chk("timeout ch1 out_renew", 64'(out_renew), 64'(r1));
        chk("timeout ch1 out_data", 64'(out_data), 64'(mkframe(1, r1)));
      end
    end
    chk("timeout unhealthy cycle", 64'(t_unh), 64'(TO));
    chk("timeout switch cycle", 64'(t_sw), 64'(TO + 1));
    chk("timeout comm_state", 64'(comm_state), 64'h0152);

    // ch0 resumes: 15 good, 1 err, 16 good
    for (int rd = 1; rd <= 32; rd++) begin
      r1++;
      if (rd == 16) frame(2'b10, 2'b01, r0, r1);
      else begin
        r0++;
        frame(2'b11, 2'b00, r0, r1);
      end
      if (rd == 32) chk("revert frame from old ch", 64'(out_renew), 64'(r1));
      idle(3);
      if (rd == 15 || rd == 16 || rd == 31)
        chk($sformatf("no revert round %0d", rd), 64'(active_ch), 64'd1);
    end
    chk("revert comm_state", 64'(comm_state), 64'h0243);
    r0++; r1++;
    frame(2'b11, 2'b00, r0, r1);
    chk("revert ch0 fwd valid", 64'(out_valid), 64'd1);
    chk("revert ch0 fwd renew", 64'(out_renew), 64'(r0));
    idle(3);

    // ch0 repeats renew=5
    for (int rd = 1; rd <= 5; rd++) begin
      r1++;
      frame(2'b11, 2'b00, 16'd5, r1);
      if (rd == 4) chk("stale ch0 healthy after 4", 64'(comm_state[0]), 64'd1);
      if (rd == 5) chk("stale ch0 unhealthy after 5", 64'(comm_state[0]), 64'd0);
      idle(3);
    end
    chk("stale comm_state", 64'(comm_state), 64'h0352);

    // same-cycle valid+err on active ch1
    frame(2'b10, 2'b10, r0, r1);
    chk("valid+err out_valid", 64'(out_valid), 64'd0);
    chk("valid+err comm_state", 64'(comm_state), 64'h0352);

    // ch0 recovers, ch1 times out
    r0++;
    frame(2'b01, 2'b00, r0, r1);
    chk("inactive ch0 not fwd", 64'(out_valid), 64'd0);
    idle(1);
    chk("recover revert comm", 64'(comm_state), 64'h0443);
    for (int m = 1; m <= 48; m++) begin
      if (m % 8 == 0) begin
        r0++;
        rx_valid = 2'b01;
        rx_renew[15:0] = r0;
      end
      tick();
      rx_valid = '0;
    end
    chk("ch1 timed out comm", 64'(comm_state), 64'h0441);

    force_en = 1'b1; force_ch = 2'd3;
    tick();
    chk("force ch3 ignored", 64'(comm_state), 64'h0441);
    force_ch = 2'd1;
    tick();
    chk("force ch1 comm", 64'(comm_state), 64'h0591);
    chk("force ch1 active_ch", 64'(active_ch), 64'd1);
    chk("force ch1 link_ok", 64'(link_ok), 64'd0);
    for (int m = 1; m <= 16; m++) begin
      if (m == 4 || m == 12) begin
        r0++;
        rx_valid = 2'b01;
        rx_renew[15:0] = r0;
      end
      tick();
      rx_valid = '0;
      if (m == 4 || m == 12) chk($sformatf("forced ch0 not fwd m%0d", m), 64'(out_valid), 64'd0);
    end
    chk("forced no auto switch", 64'(comm_state), 64'h0591);
    force_en = 1'b0;
    tick();
    chk("release to no_link", 64'(comm_state), 64'h0511);
    tick();
    chk("relock ch0", 64'(comm_state), 64'h0641);
    r0++;
    frame(2'b01, 2'b00, r0, r1);
    chk("relock fwd valid", 64'(out_valid), 64'd1);
    chk("relock fwd renew", 64'(out_renew), 64'(r0));
    last = r0;

    // all silent
    idle(50);
    chk("silent comm_state", 64'(comm_state), 64'h0600);
    chk("silent link_ok", 64'(link_ok), 64'd0);
    chk("silent out_renew hold", 64'(out_renew), 64'(last));
    chk("silent out_data hold", 64'(out_data), 64'(mkframe(0, last)));

    // async reset in the middle of a frame cycle
    r0++;
    rx_valid = 2'b01;
    rx_renew[15:0] = r0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset out_data", 64'(out_data), 64'd0);
    chk("areset out_renew", 64'(out_renew), 64'd0);
    chk("areset out_valid", 64'(out_valid), 64'd0);
    chk("areset comm_state", 64'(comm_state), 64'd0);
    chk("areset active_ch", 64'(active_ch), 64'd0);
    chk("areset link_ok", 64'(link_ok), 64'd0);
    @(negedge clk_100M);
    rx_valid = '0;
    reset_n = 1'b1;
    tick();
    chk("post reset out_valid", 64'(out_valid), 64'd0);
    chk("post reset comm_state", 64'(comm_state), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
